// File: rtl/speed_switch_controller.sv
// speed_switch_controller
// KEY1 speed-switch sequencer. The CPU arms a switch by writing the prepare
// bit. A later STOP holds the CPU clock for a fixed period, flips the divider
// mode, holds again while the divider settles, then releases the CPU with a
// one-cycle acknowledge.
module speed_switch_controller #(
    parameter int unsigned SWITCH_DELAY = 8192,  // hold cycles before the mode flip, 2..65535
    parameter int unsigned SETTLE_DELAY = 16     // hold cycles after the mode flip, 1..65535
) (
    input  logic       sclk,
    input  logic       rst,
    input  logic       cgbEnable,
    input  logic       regWrite,
    input  logic [7:0] regDataIn,
    output logic [7:0] regDataOut,
    input  logic       stopReq,
    output logic       stopAck,
    output logic       cgbMode,
    output logic       clockHold,
    output logic       busy
);

    // All four 2-bit codes are real states, so no illegal code can persist.
    // The default arm of the case still returns to IDLE.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        HOLD   = 2'b01,
        SWITCH = 2'b10,
        SETTLE = 2'b11
    } state_t;

    // Terminal counts. Both are compared against a 16-bit counter. The
    // parameter ranges keep them at or below 65534, so the counter cannot
    // wrap before it matches.
    localparam logic [15:0] SWITCH_LAST = 16'(SWITCH_DELAY - 1);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_DELAY - 1);

    state_t      state_reg;
    logic [15:0] count_reg;
    logic        prepare_reg;
    logic        cgb_mode_reg;
    logic        clock_hold_reg;
    logic        busy_reg;
    logic        stop_ack_reg;

    // Only bit 0 of the write data carries information.
    logic        unused_data_bits;
    assign unused_data_bits = ^regDataIn[7:1];

    // Sequencer state, delay counter, prepare latch and registered outputs.
    always_ff @(posedge sclk) begin
        if (rst) begin
            state_reg      <= IDLE;
            count_reg      <= 16'd0;
            prepare_reg    <= 1'b0;
            cgb_mode_reg   <= 1'b0;
            clock_hold_reg <= 1'b0;
            busy_reg       <= 1'b0;
            stop_ack_reg   <= 1'b0;
        end else begin
            // The acknowledge is a single-cycle pulse unless re-raised below.
            stop_ack_reg <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (stopReq) begin
                        // A STOP in the same cycle as a write sees the old
                        // prepare value, and that write is dropped.
                        if (prepare_reg) begin
                            state_reg      <= HOLD;
                            count_reg      <= 16'd0;
                            clock_hold_reg <= 1'b1;
                            busy_reg       <= 1'b1;
                        end else begin
                            stop_ack_reg <= 1'b1;
                        end
                    end else if (regWrite && cgbEnable) begin
                        prepare_reg <= regDataIn[0];
                    end
                end

                HOLD: begin
                    // Writes and STOPs are ignored from here until IDLE.
                    count_reg <= count_reg + 16'd1;
                    if (count_reg == SWITCH_LAST) begin
                        state_reg <= SWITCH;
                    end
                end

                SWITCH: begin
                    // This is the only place the divider mode changes. A
                    // cartridge that has dropped CGB support lands in normal
                    // speed instead of toggling.
                    cgb_mode_reg <= cgbEnable ? ~cgb_mode_reg : 1'b0;
                    prepare_reg  <= 1'b0;
                    count_reg    <= 16'd0;
                    state_reg    <= SETTLE;
                end

                SETTLE: begin
                    count_reg <= count_reg + 16'd1;
                    if (count_reg == SETTLE_LAST) begin
                        state_reg      <= IDLE;
                        count_reg      <= 16'd0;
                        clock_hold_reg <= 1'b0;
                        busy_reg       <= 1'b0;
                        stop_ack_reg   <= 1'b1;
                    end
                end

                default: begin
                    state_reg      <= IDLE;
                    count_reg      <= 16'd0;
                    clock_hold_reg <= 1'b0;
                    busy_reg       <= 1'b0;
                end
            endcase

            // Losing CGB support always disarms a pending switch. This does
            // not abort a sequence that is already running.
            if (!cgbEnable) begin
                prepare_reg <= 1'b0;
            end
        end
    end

    // KEY1 readback. Unused bits read as ones.
    assign regDataOut = {cgb_mode_reg, 6'b111111, prepare_reg};

    assign stopAck   = stop_ack_reg;
    assign cgbMode   = cgb_mode_reg;
    assign clockHold = clock_hold_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_speed_switch_controller.sv
// Testbench for speed_switch_controller. Each STOP pushes its expected
// acknowledge cycle, final mode and hold count onto a scoreboard queue. The
// entry is popped and compared when the acknowledge appears.
module tb_speed_switch_controller;

    localparam int SD = 200;
    localparam int ST = 10;

    logic       sclk = 1'b0;
    logic       rst;
    logic       cgbEnable;
    logic       regWrite;
    logic [7:0] regDataIn;
    logic [7:0] regDataOut;
    logic       stopReq;
    logic       stopAck;
    logic       cgbMode;
    logic       clockHold;
    logic       busy;

    int checks    = 0;
    int errors    = 0;
    int cyc       = 0;
    int ack_count = 0;

    typedef struct {
        int   cyc;
        logic mode;
        int   holds;
    } exp_t;

    exp_t sb[$];

    speed_switch_controller #(
        .SWITCH_DELAY(SD),
        .SETTLE_DELAY(ST)
    ) dut (
        .sclk      (sclk),
        .rst       (rst),
        .cgbEnable (cgbEnable),
        .regWrite  (regWrite),
        .regDataIn (regDataIn),
        .regDataOut(regDataOut),
        .stopReq   (stopReq),
        .stopAck   (stopAck),
        .cgbMode   (cgbMode),
        .clockHold (clockHold),
        .busy      (busy)
    );

    always #5 sclk = ~sclk;

    // Count rising edges.
    always @(posedge sclk) cyc <= cyc + 1;

    // Count every acknowledge pulse, including unexpected ones.
    always @(negedge sclk) if (stopAck === 1'b1) ack_count <= ack_count + 1;

    task automatic do_write(input logic [7:0] d);
        @(negedge sclk);
        regWrite  = 1'b1;
        regDataIn = d;
        @(negedge sclk);
        regWrite  = 1'b0;
        regDataIn = 8'h00;
    endtask

    // Issue one STOP and follow it to its acknowledge.
    task automatic issue_stop(input int lat, input logic exp_mode, input bit inject,
                              input bit with_write, input bit drop_en, input string name);
        exp_t e;
        exp_t q;
        int   t0;
        int   holds;
        int   ack_cyc;
        int   a0;
        bit   got;
        holds   = 0;
        got     = 1'b0;
        ack_cyc = -1;
        @(negedge sclk);
        a0      = ack_count;
        stopReq = 1'b1;
        if (with_write) begin
            regWrite  = 1'b1;
            regDataIn = 8'h01;
        end
        t0      = cyc;
        e.cyc   = t0 + lat;
        e.mode  = exp_mode;
        e.holds = lat - 1;
        sb.push_back(e);
        for (int i = 0; i < lat + 10 && !got; i++) begin
            @(negedge sclk);
            stopReq   = 1'b0;
            regWrite  = 1'b0;
            regDataIn = 8'h00;
            if (clockHold === 1'b1) holds++;
            if (stopAck === 1'b1) begin
                got     = 1'b1;
                ack_cyc = cyc;
            end else begin
                if (inject && i == 5) begin
                    stopReq   = 1'b1;
                    regWrite  = 1'b1;
                    regDataIn = 8'h00;
                end
                if (inject && i == 7) begin
                    checks++;
                    if (regDataOut[0] !== 1'b1) begin
                        errors++;
                        $display("FAIL %s busy_write_prepare: got %b expected 1", name, regDataOut[0]);
                    end
                end
                if (inject && i == SD + 4) stopReq = 1'b1;
                if (drop_en && i == 3) cgbEnable = 1'b0;
            end
        end
        q = sb.pop_front();
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s ack_timeout: no stopAck within %0d cycles, expected at cycle %0d", name, lat + 10, q.cyc);
        end else begin
            checks++;
            if (ack_cyc !== q.cyc) begin
                errors++;
                $display("FAIL %s ack_latency: got %0d expected %0d", name, ack_cyc - t0, q.cyc - t0);
            end
            checks++;
            if (cgbMode !== q.mode) begin
                errors++;
                $display("FAIL %s cgbMode: got %b expected %b", name, cgbMode, q.mode);
            end
            checks++;
            if (holds !== q.holds) begin
                errors++;
                $display("FAIL %s hold_cycles: got %0d expected %0d", name, holds, q.holds);
            end
            checks++;
            if (busy !== 1'b0 || clockHold !== 1'b0) begin
                errors++;
                $display("FAIL %s release: got busy=%b hold=%b expected 0 0", name, busy, clockHold);
            end
        end
        repeat (3) @(negedge sclk);
        checks++;
        if (ack_count - a0 !== 1) begin
            errors++;
            $display("FAIL %s ack_count: got %0d expected 1", name, ack_count - a0);
        end
        $display("stop %s: latency %0d mode %b holds %0d", name, ack_cyc - t0, cgbMode, holds);
    endtask

    task automatic test_reset();
        // Reset must win over an active write and STOP.
        rst       = 1'b1;
        cgbEnable = 1'b1;
        regWrite  = 1'b1;
        regDataIn = 8'h01;
        stopReq   = 1'b1;
        repeat (3) @(negedge sclk);
        checks++;
        if (regDataOut !== 8'h7E || cgbMode !== 1'b0 || clockHold !== 1'b0 ||
            busy !== 1'b0 || stopAck !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got out=%h mode=%b hold=%b busy=%b ack=%b expected 7e 0 0 0 0",
                     regDataOut, cgbMode, clockHold, busy, stopAck);
        end
        rst       = 1'b0;
        regWrite  = 1'b0;
        regDataIn = 8'h00;
        stopReq   = 1'b0;
        @(negedge sclk);
        checks++;
        if (regDataOut !== 8'h7E || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got out=%h busy=%b expected 7e 0", regDataOut, busy);
        end
        $display("reset: out=%h", regDataOut);
    endtask

    task automatic test_prepare_write();
        do_write(8'h01);
        checks++;
        if (regDataOut !== 8'h7F) begin
            errors++;
            $display("FAIL prepare_write: got %h expected 7f", regDataOut);
        end
        $display("write 01: out=%h", regDataOut);
    endtask

    task automatic test_full_switch();
        issue_stop(SD + ST + 2, 1'b1, 1'b0, 1'b0, 1'b0, "full_switch");
        checks++;
        if (regDataOut !== 8'hFE) begin
            errors++;
            $display("FAIL full_switch_readback: got %h expected fe", regDataOut);
        end
    endtask

    task automatic test_no_prepare();
        issue_stop(1, 1'b1, 1'b0, 1'b0, 1'b0, "no_prepare");
    endtask

    task automatic test_switch_back();
        do_write(8'h01);
        checks++;
        if (regDataOut !== 8'hFF) begin
            errors++;
            $display("FAIL switch_back_prepare: got %h expected ff", regDataOut);
        end
        issue_stop(SD + ST + 2, 1'b0, 1'b0, 1'b0, 1'b0, "switch_back");
        checks++;
        if (regDataOut !== 8'h7E) begin
            errors++;
            $display("FAIL switch_back_readback: got %h expected 7e", regDataOut);
        end
    endtask

    task automatic test_busy_ignore();
        do_write(8'h01);
        issue_stop(SD + ST + 2, 1'b1, 1'b1, 1'b0, 1'b0, "busy_ignore");
    endtask

    task automatic test_reset_abort();
        int a0;
        do_write(8'h01);
        @(negedge sclk);
        stopReq = 1'b1;
        @(negedge sclk);
        stopReq = 1'b0;
        repeat (99) @(negedge sclk);
        checks++;
        if (clockHold !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_in_hold: got hold=%b busy=%b expected 1 1", clockHold, busy);
        end
        a0  = ack_count;
        rst = 1'b1;
        @(negedge sclk);
        rst = 1'b0;
        checks++;
        if (clockHold !== 1'b0 || busy !== 1'b0 || cgbMode !== 1'b0 || stopAck !== 1'b0) begin
            errors++;
            $display("FAIL abort_outputs: got hold=%b busy=%b mode=%b ack=%b expected 0 0 0 0",
                     clockHold, busy, cgbMode, stopAck);
        end
        repeat (SD + ST + 20) @(negedge sclk);
        checks++;
        if (ack_count !== a0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_ack: got acks=%0d busy=%b expected 0 0", ack_count - a0, busy);
        end
        $display("reset abort: mode=%b acks=%0d", cgbMode, ack_count - a0);
    endtask

    task automatic test_cgb_disabled();
        do_write(8'h01);
        checks++;
        if (regDataOut !== 8'h7F) begin
            errors++;
            $display("FAIL disable_setup: got %h expected 7f", regDataOut);
        end
        @(negedge sclk);
        cgbEnable = 1'b0;
        @(negedge sclk);
        checks++;
        if (regDataOut !== 8'h7E) begin
            errors++;
            $display("FAIL disable_clears_prepare: got %h expected 7e", regDataOut);
        end
        do_write(8'h01);
        checks++;
        if (regDataOut !== 8'h7E) begin
            errors++;
            $display("FAIL disabled_write: got %h expected 7e", regDataOut);
        end
        cgbEnable = 1'b1;
        $display("cgb disabled: out=%h", regDataOut);
    endtask

    task automatic test_same_cycle();
        issue_stop(1, 1'b0, 1'b0, 1'b1, 1'b0, "same_cycle");
        checks++;
        if (regDataOut !== 8'h7E) begin
            errors++;
            $display("FAIL same_cycle_write_dropped: got %h expected 7e", regDataOut);
        end
    endtask

    task automatic test_enable_drop();
        do_write(8'h01);
        issue_stop(SD + ST + 2, 1'b0, 1'b0, 1'b0, 1'b1, "enable_drop");
        cgbEnable = 1'b1;
    endtask

    initial begin
        test_reset();
        test_prepare_write();
        test_full_switch();
        test_no_prepare();
        test_switch_back();
        test_busy_ignore();
        test_reset_abort();
        test_cgb_disabled();
        test_same_cycle();
        test_enable_drop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/speed_switch_controller.md
SPEED_SWITCH_CONTROLLER -- requirements
Module: speed_switch_controller

Interface
REQ-001 Parameter: SWITCH_DELAY, default 8192, sclk cycles the CPU clock is held during a speed switch (range 2..65535).
REQ-002 Parameter: SETTLE_DELAY, default 16, sclk cycles held after the divider mode changes (range 1..65535).
REQ-003 Port: sclk  in  1  system clock; the only clock.
REQ-004 Port: rst  in  1  synchronous, active-high reset, sampled on posedge sclk.
REQ-005 Port: cgbEnable  in  1  cartridge/boot has enabled CGB features; level.
REQ-006 Port: regWrite  in  1  one-cycle write strobe to the KEY1 speed register.
REQ-007 Port: regDataIn  in  8  write data; only bit 0 (prepare) is used.
REQ-008 Port: regDataOut  out  8  KEY1 readback, combinational: {cgbMode, 6'b111111, prepare}.
REQ-009 Port: stopReq  in  1  one-cycle pulse: CPU executed STOP.
REQ-010 Port: stopAck  out  1  one-cycle pulse: STOP handling finished, CPU may resume.
REQ-011 Port: cgbMode  out  1  registered speed select driven to the clock divider (1 = double speed).
REQ-012 Port: clockHold  out  1  registered; 1 = CPU clock enable must be gated off.
REQ-013 Port: busy  out  1  registered; 1 while state is not IDLE.

Function
REQ-014 The controller SHALL implement states IDLE, HOLD, SWITCH, SETTLE; the state register SHALL be encoded so that no unused encoding can persist for more than one cycle (unused encoding -> IDLE).
REQ-015 The prepare bit SHALL be set to regDataIn[0] on regWrite only when state is IDLE, cgbEnable=1 and stopReq=0; otherwise the write SHALL be discarded.
REQ-016 If cgbEnable=0, prepare SHALL be forced to 0 on the next edge.
REQ-017 In IDLE, stopReq with prepare=0 SHALL produce stopAck=1 on the next cycle with no state change and no clockHold.
REQ-018 In IDLE, stopReq with prepare=1 SHALL move to HOLD on the next edge, with clockHold=1, busy=1 and the 16-bit delay counter cleared to 0 at that same edge.
REQ-019 In HOLD, the counter SHALL increment each cycle; when the counter equals SWITCH_DELAY-1, the next state SHALL be SWITCH.
REQ-020 In SWITCH (exactly one cycle), on leaving it: cgbMode SHALL toggle, prepare SHALL clear, the counter SHALL clear, and the next state SHALL be SETTLE.
REQ-021 In SETTLE, the counter SHALL increment; when the counter equals SETTLE_DELAY-1, the next state SHALL be IDLE, with clockHold=0, busy=0 and stopAck=1 for exactly that first IDLE cycle.
REQ-022 Total latency from the stopReq cycle T to the stopAck cycle SHALL be SWITCH_DELAY + SETTLE_DELAY + 2 cycles; clockHold SHALL be 1 for cycles T+1 through T+SWITCH_DELAY+SETTLE_DELAY+1.
REQ-023 stopReq and regWrite SHALL be ignored while busy=1.
REQ-024 A stopReq and regWrite in the same IDLE cycle: stopReq SHALL use the pre-write prepare value, and the write SHALL be discarded.
REQ-025 cgbMode SHALL change only on the SWITCH->SETTLE edge; it SHALL never change while clockHold=0.
REQ-026 cgbEnable falling during HOLD/SETTLE SHALL NOT abort the sequence; if cgbEnable=0 at the SWITCH->SETTLE edge, cgbMode SHALL be forced to 0 instead of toggling.
REQ-027 The counter SHALL NOT wrap; parameter range guarantees a terminal match is reached before overflow.

Reset
REQ-028 While rst=1 at a posedge: state=IDLE, counter=0, prepare=0, cgbMode=0, clockHold=0, busy=0, stopAck=0; regDataOut reads 8'h7E.
REQ-029 Reset mid-sequence (HOLD/SWITCH/SETTLE) SHALL abort with no stopAck, and all outputs SHALL take their reset values on the next edge.
REQ-030 rst SHALL take priority over every other input in the same cycle.

Verification
REQ-031 Reset, cgbEnable=1, regWrite 8'h01, then read -> regDataOut=8'h7F; stopReq -> clockHold=1 for SWITCH_DELAY+SETTLE_DELAY+1 cycles, then cgbMode=1, regDataOut=8'hFE, single stopAck at T+SWITCH_DELAY+SETTLE_DELAY+2.
REQ-032 With prepare=0, stopReq -> stopAck at T+1; clockHold stays 0; cgbMode unchanged.
REQ-033 From cgbMode=1, prepare then stopReq -> cgbMode returns to 0 after the full sequence; regDataOut=8'h7E.
REQ-034 rst asserted 100 cycles into HOLD -> next cycle: clockHold=0, busy=0, cgbMode=0, and no stopAck ever appears.
REQ-035 cgbEnable=0, regWrite 8'h01 -> prepare stays 0; the same-cycle regWrite 8'h01 + stopReq in IDLE -> immediate stopAck, no switch; stopReq/regWrite pulses during busy -> exactly one stopAck, and prepare is unaffected by the writes.
